xor4_sweep_ctrl: RTL

Sequencer and self-checker for the 4-input XOR datapath. On a start pulse it drives all 16 input combinations {a,b,c,d} in ascending order and holds each for a programmable dwell. On the last cycle of each dwell it samples the datapath's three outputs and compares them with the expected parity values. It reports pass/fail, a mismatch count and the first failing vector, and sits beside the datapath as its on-chip stimulus/check controller.

---
 rtl/xor4_sweep_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/xor4_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | xor4_sweep_ctrl: walks all 16 {a,b,c,d} vectors through the 4-input   |
// | XOR datapath and checks e/f/g against parity.  Rev 1.0                 |
// +------------------------------------------------------------------------+
module xor4_sweep_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  input  logic       dut_e,
  input  logic       dut_f,
  input  logic       dut_g,
  output logic [3:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_valid,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST_DCNT = 8'(DWELL - 1);
  localparam logic [3:0] C_LAST_VEC  = 4'd15;

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [4:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [3:0] ff_q, ff_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] w_expected;
  logic       w_mismatch;
  logic       w_sample;
  logic [4:0] w_err_next;

  // Reference parity for the vector currently applied to the datapath.
  assign w_expected = {vec_q[3] ^ vec_q[2], vec_q[1] ^ vec_q[0], ^vec_q};
  assign w_mismatch = ({dut_e, dut_f, dut_g} != w_expected);
  assign w_sample   = (state_q == S_RUN) && (dcnt_q == C_LAST_DCNT);
  assign w_err_next = (w_sample && w_mismatch) ? err_q + 5'd1 : err_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      vec_d   = 4'd0;
      dcnt_d  = 8'd0;
      err_d   = 5'd0;
      fv_d    = 1'b0;
      ff_d    = 4'd0;
      pass_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            vec_d   = 4'd0;
            dcnt_d  = 8'd0;
            err_d   = 5'd0;
            fv_d    = 1'b0;
            ff_d    = 4'd0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_RUN: begin
          if (dcnt_q == C_LAST_DCNT) begin
            err_d = w_err_next;
            if (w_mismatch && !fv_q) begin
              fv_d = 1'b1;
              ff_d = vec_q;
            end
            dcnt_d = 8'd0;
            if (vec_q == C_LAST_VEC) begin
              // Final verdict must already include vector 15's result.
              state_d = S_DONE;
              vec_d   = 4'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (w_err_next == 5'd0);
            end else begin
              vec_d = vec_q + 4'd1;
            end
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          vec_d   = 4'd0;
          dcnt_d  = 8'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      dcnt_q  <= 8'd0;
      err_q   <= 5'd0;
      fv_q    <= 1'b0;
      ff_q    <= 4'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vec        = vec_q;
  assign dut_a      = vec_q[3];
  assign dut_b      = vec_q[2];
  assign dut_c      = vec_q[1];
  assign dut_d      = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule
`default_nettype wire
